maple_transmitter: RTL and testbench



---
 rtl/maple_transmitter.sv | 203 ++++++++++++++++++++
 tb/tb_maple_transmitter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/maple_transmitter.sv
// Maple bus frame transmitter: serializes a valid/ready byte stream onto SDCKA/SDCKB
// using the alternating two-wire clock encoding, with start/end framing and pad output-enable.
module maple_transmitter #(
  parameter int PHASE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       sdcka_out,
  output logic       sdckb_out,
  output logic       sdck_oe,
  output logic       busy,
  output logic       tx_done
);

  localparam int            CW       = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(PHASE_CYCLES - 1);
  // The WAIT cycle is the final cycle of bit 0's (1,0) phase, so a byte that is
  // ready immediately costs no extra time; with one-cycle phases WAIT is that whole phase.
  localparam logic [CW-1:0] WAIT_CNT = CW'((PHASE_CYCLES > 1) ? PHASE_CYCLES - 2 : 0);
  localparam logic [1:0]    WAIT_SUB = (PHASE_CYCLES > 1) ? 2'd2 : 2'd1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_WAIT, S_END} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_idx;
  logic [2:0]    r_bit;
  logic [1:0]    r_sub;
  logic [7:0]    r_shift;
  logic          r_last;
  logic          r_a;
  logic          r_b;
  logic          r_active;
  logic          r_done;

  logic          w_accept;
  logic          w_phase_end;
  logic          w_enter_wait;
  logic [3:0]    w_idx_inc;
  logic [2:0]    w_bit_dec;
  logic [1:0]    w_sub_inc;
  logic [CW-1:0] w_cnt_inc;

  // {A,B} for one of the three phases of a bit; odd bits clock on A, even bits on B.
  function automatic logic [1:0] bit_ab(input logic a_clocked, input logic [1:0] sub,
                                        input logic d);
    logic [1:0] ab;
    ab = 2'b11;
    if (a_clocked) begin
      case (sub)
        2'd0:    ab = {1'b1, d};
        2'd1:    ab = {1'b0, d};
        default: ab = 2'b01;
      endcase
    end else begin
      case (sub)
        2'd0:    ab = {d, 1'b1};
        2'd1:    ab = {d, 1'b0};
        default: ab = 2'b10;
      endcase
    end
    return ab;
  endfunction

  function automatic logic [1:0] start_ab(input logic [3:0] idx);
    logic [1:0] ab;
    if (idx == 4'd9)   ab = 2'b11;
    else if (idx[0])   ab = 2'b00;
    else               ab = 2'b01;
    return ab;
  endfunction

  function automatic logic [1:0] end_ab(input logic [2:0] idx);
    logic [1:0] ab;
    if (idx == 3'd4)   ab = 2'b11;
    else if (idx[0])   ab = 2'b10;
    else               ab = 2'b00;
    return ab;
  endfunction

  assign tx_ready     = (r_state == S_IDLE) || (r_state == S_WAIT);
  assign w_accept     = tx_valid && tx_ready;
  assign w_phase_end  = (r_cnt == CNT_MAX);
  assign w_enter_wait = (r_state == S_BIT) && (r_bit == 3'd0) && !r_last &&
                        (r_sub == WAIT_SUB) && (r_cnt == WAIT_CNT);
  assign w_idx_inc    = r_idx + 4'd1;
  assign w_bit_dec    = r_bit - 3'd1;
  assign w_sub_inc    = r_sub + 2'd1;
  assign w_cnt_inc    = r_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_bit    <= '0;
      r_sub    <= '0;
      r_shift  <= '0;
      r_last   <= 1'b0;
      r_a      <= 1'b1;
      r_b      <= 1'b1;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift      <= tx_data;
            r_last       <= tx_last;
            r_state      <= S_START;
            r_cnt        <= '0;
            r_idx        <= '0;
            {r_a, r_b}   <= 2'b01;
            r_active     <= 1'b1;
          end
        end
        S_START: begin
          if (w_phase_end) begin
            r_cnt <= '0;
            if (r_idx == 4'd9) begin
              r_state    <= S_BIT;
              r_bit      <= 3'd7;
              r_sub      <= 2'd0;
              {r_a, r_b} <= bit_ab(1'b1, 2'd0, r_shift[7]);
            end else begin
              r_idx      <= w_idx_inc;
              {r_a, r_b} <= start_ab(w_idx_inc);
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_BIT: begin
          if (w_enter_wait) begin
            r_state    <= S_WAIT;
            r_cnt      <= '0;
            {r_a, r_b} <= 2'b10;
          end else if (w_phase_end) begin
            r_cnt <= '0;
            if (r_sub == 2'd2) begin
              // Only the final byte reaches the end of bit 0 here; others divert to WAIT.
              if (r_bit == 3'd0) begin
                r_state    <= S_END;
                r_idx      <= '0;
                {r_a, r_b} <= 2'b00;
              end else begin
                r_bit      <= w_bit_dec;
                r_sub      <= 2'd0;
                r_shift    <= {r_shift[6:0], 1'b0};
                {r_a, r_b} <= bit_ab(w_bit_dec[0], 2'd0, r_shift[6]);
              end
            end else begin
              r_sub      <= w_sub_inc;
              {r_a, r_b} <= bit_ab(r_bit[0], w_sub_inc, r_shift[7]);
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT: begin
          if (w_accept) begin
            r_shift    <= tx_data;
            r_last     <= tx_last;
            r_state    <= S_BIT;
            r_bit      <= 3'd7;
            r_sub      <= 2'd0;
            r_cnt      <= '0;
            {r_a, r_b} <= bit_ab(1'b1, 2'd0, tx_data[7]);
          end
        end
        S_END: begin
          if (w_phase_end) begin
            r_cnt <= '0;
            if (r_idx == 4'd4) begin
              r_state    <= S_IDLE;
              r_active   <= 1'b0;
              r_done     <= 1'b1;
              {r_a, r_b} <= 2'b11;
            end else begin
              r_idx      <= w_idx_inc;
              {r_a, r_b} <= end_ab(w_idx_inc[2:0]);
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sdcka_out = r_a;
  assign sdckb_out = r_b;
  assign sdck_oe   = r_active;
  assign busy      = r_active;
  assign tx_done   = r_done;

endmodule

// File: tb/tb_maple_transmitter.sv
// Directed bench for maple_transmitter: one instance with 1-cycle phases, one with 8-cycle phases.
module tb_maple_transmitter;

  typedef struct packed {
    logic a;
    logic b;
    logic rdy;
    logic feed;
  } ent_t;

  logic       clk;
  logic       reset;
  logic       sel;
  logic       tx_valid;
  logic       tx_last;
  logic [7:0] tx_data;

  logic a1, b1, oe1, busy1, rdy1, done1;
  logic a8, b8, oe8, busy8, rdy8, done8;
  wire [5:0] obs1 = {a1, b1, oe1, busy1, rdy1, done1};
  wire [5:0] obs8 = {a8, b8, oe8, busy8, rdy8, done8};

  int         tests;
  int         failed;
  ent_t       q[$];
  logic [7:0] fb[4];
  logic [38:0] a5_a;
  logic [38:0] a5_b;

  maple_transmitter #(.PHASE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid && !sel), .tx_ready(rdy1), .sdcka_out(a1), .sdckb_out(b1),
    .sdck_oe(oe1), .busy(busy1), .tx_done(done1)
  );

  maple_transmitter #(.PHASE_CYCLES(8)) u_dut8 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid && sel), .tx_ready(rdy8), .sdcka_out(a8), .sdckb_out(b8),
    .sdck_oe(oe8), .busy(busy8), .tx_done(done8)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] cur_obs();
    return sel ? obs8 : obs1;
  endfunction

  task automatic check(input string tag, input logic [5:0] o, input logic [5:0] e);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s observed {a,b,oe,busy,ready,done}=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Expected {A,B} for phase p (0..23) of a byte, straight from the encoding rules.
  function automatic logic [1:0] exp_ab(input logic [7:0] byt, input int p);
    int   bi;
    int   s;
    logic d;
    bi = 7 - p / 3;
    s  = p % 3;
    d  = byt[bi];
    if (bi % 2 == 1) begin
      if (s == 0)      return {1'b1, d};
      else if (s == 1) return {1'b0, d};
      else             return 2'b01;
    end else begin
      if (s == 0)      return {d, 1'b1};
      else if (s == 1) return {d, 1'b0};
      else             return 2'b10;
    end
  endfunction

  task automatic push_ph(input logic a, input logic b, input int pc);
    for (int i = 0; i < pc; i++) q.push_back({a, b, 1'b0, 1'b0});
  endtask

  task automatic build(input int n, input int pc, input int stall_after, input int stall_len);
    logic [1:0] ab;
    q.delete();
    push_ph(1'b0, 1'b1, pc);
    for (int i = 1; i <= 8; i++) push_ph(1'b0, (i % 2 == 0), pc);
    push_ph(1'b1, 1'b1, pc);
    for (int k = 0; k < n; k++) begin
      for (int p = 0; p < 24; p++) begin
        ab = exp_ab(fb[k], p);
        if (p == 23 && k < n - 1) begin
          for (int j = 0; j < pc - 1; j++) q.push_back({1'b1, 1'b0, 1'b0, 1'b0});
          if (k == stall_after)
            for (int j = 0; j < stall_len; j++) q.push_back({1'b1, 1'b0, 1'b1, 1'b0});
          q.push_back({1'b1, 1'b0, 1'b1, 1'b1});
        end else begin
          push_ph(ab[1], ab[0], pc);
        end
      end
    end
    push_ph(1'b0, 1'b0, pc);
    push_ph(1'b1, 1'b0, pc);
    push_ph(1'b0, 1'b0, pc);
    push_ph(1'b1, 1'b0, pc);
    push_ph(1'b1, 1'b1, pc);
  endtask

  task automatic run(input string tag, input int n, input logic garbage, input int exp_oe);
    int         nxt;
    int         oe_cnt;
    int         done_cnt;
    ent_t       e;
    logic [5:0] o;
    @(negedge clk);
    check($sformatf("%s idle", tag), cur_obs(), 6'b110010);
    tx_valid = 1'b1;
    tx_data  = fb[0];
    tx_last  = (n == 1);
    nxt      = 1;
    oe_cnt   = 0;
    done_cnt = 0;
    for (int c = 0; c < q.size(); c++) begin
      @(negedge clk);
      e = q[c];
      o = cur_obs();
      check($sformatf("%s c%0d", tag, c), o, {e.a, e.b, 1'b1, 1'b1, e.rdy, 1'b0});
      if (o[3]) oe_cnt++;
      if (o[0]) done_cnt++;
      if (e.feed) begin
        tx_valid = 1'b1;
        tx_data  = fb[nxt];
        tx_last  = (nxt == n - 1);
        nxt++;
      end else if (garbage && !e.rdy) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
        tx_last  = 1'($urandom);
      end else begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        tx_last  = 1'($urandom);
      end
    end
    @(negedge clk);
    o = cur_obs();
    tx_valid = 1'b0;
    check($sformatf("%s tail", tag), o, 6'b110011);
    if (o[0]) done_cnt++;
    @(negedge clk);
    o = cur_obs();
    check($sformatf("%s done_clr", tag), o, 6'b110010);
    if (o[0]) done_cnt++;
    check_int($sformatf("%s oe_cycles", tag), oe_cnt, exp_oe);
    check_int($sformatf("%s done_pulses", tag), done_cnt, 1);
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    sel      = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = 8'h00;
    tests    = 0;
    failed   = 0;
    a5_a = 39'b0000000001_100001100001100111100111_01011;
    a5_b = 39'b1010101011_111100111100001100001100_00001;

    // Reset values on both instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pc1", obs1, 6'b110010);
    check("rst_pc8", obs8, 6'b110010);
    reset = 1'b0;

    // PHASE_CYCLES=1, single byte 0xA5, hand-written 39-phase trace.
    sel   = 1'b0;
    fb[0] = 8'hA5;
    q.delete();
    for (int i = 0; i < 39; i++) q.push_back({a5_a[38-i], a5_b[38-i], 1'b0, 1'b0});
    run("a5_pc1", 1, 1'b0, 39);

    // PHASE_CYCLES=1, four 0x00 bytes with garbage valid/data while busy.
    fb[0] = 8'h00; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00;
    build(4, 1, -1, 0);
    run("zeros_pc1", 4, 1'b1, 111);

    // PHASE_CYCLES=1, two bytes with a 5-cycle underrun and garbage.
    fb[0] = 8'h96; fb[1] = 8'h69;
    build(2, 1, 0, 5);
    run("stall_pc1", 2, 1'b1, 68);

    // PHASE_CYCLES=8, 0x01 then 0xFF back to back.
    sel   = 1'b1;
    fb[0] = 8'h01; fb[1] = 8'hFF;
    build(2, 8, -1, 0);
    run("b2b_pc8", 2, 1'b0, 504);

    // PHASE_CYCLES=8, second byte withheld 100 cycles.
    fb[0] = 8'h3C; fb[1] = 8'hC3;
    build(2, 8, 0, 100);
    run("underrun_pc8", 2, 1'b1, 604);

    // PHASE_CYCLES=8, reset during bit phase of byte 1, then a clean frame.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hE7;
    tx_last  = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (110) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_pc8", obs8, 6'b110010);
    reset = 1'b0;
    fb[0] = 8'h5A;
    build(1, 8, -1, 0);
    run("after_rst_pc8", 1, 1'b1, 312);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
